// File: rtl/store_sequencer_if.sv
// Control-unit side bundle of the store sequencer:
// start/type request in, memory-store controls and status out.
interface store_sequencer_if;
  logic       start;
  logic [1:0] store_type;
  logic       mem_wr;
  logic       mux_wd_sel;
  logic       mdr_load;
  logic [1:0] ss_ctrl;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output start, store_type,
    input  mem_wr, mux_wd_sel, mdr_load,
    input  ss_ctrl, busy, done, error
  );

  modport slave (
    input  start, store_type,
    output mem_wr, mux_wd_sel, mdr_load,
    output ss_ctrl, busy, done, error
  );
endinterface

// File: rtl/store_sequencer.sv
// Multicycle store controller: sw writes B directly,
// sh/sb read the word into MDR and write the merged result.
module store_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  store_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE_B,
    S_READ,
    S_WAIT,
    S_LATCH,
    S_WRITE_M,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] typ_q, typ_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      typ_q   <= 2'b00;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      typ_q   <= typ_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    typ_d   = typ_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          typ_d = bus.store_type;
          unique case (bus.store_type)
            2'b00:        state_d = S_WRITE_B;
            2'b01, 2'b10: state_d = S_READ;
            default:      state_d = S_ERR;
          endcase
        end
      end
      S_WRITE_B: state_d = S_DONE;
      S_READ: begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: begin
        // counter reaches zero on the last cycle of read latency
        if (cnt_q == 3'd0) state_d = S_LATCH;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_LATCH:   state_d = S_WRITE_M;
      S_WRITE_M: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_wr     = 1'b0;
    bus.mux_wd_sel = 1'b0;
    bus.mdr_load   = 1'b0;
    bus.ss_ctrl    = 2'b00;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.error      = 1'b0;
    unique case (state_q)
      S_WRITE_B: begin
        bus.mem_wr = 1'b1;
        bus.busy   = 1'b1;
      end
      S_READ, S_WAIT: bus.busy = 1'b1;
      S_LATCH: begin
        bus.mdr_load = 1'b1;
        bus.busy     = 1'b1;
      end
      S_WRITE_M: begin
        bus.mem_wr     = 1'b1;
        bus.mux_wd_sel = 1'b1;
        bus.ss_ctrl    = typ_q;
        bus.busy       = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.busy = 1'b1;
      end
      S_ERR:   bus.error = 1'b1;
      default: ;
    endcase
  end

endmodule
